// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared widths and helpers for the SAD window accumulator
package sad_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int LEN_DEF   = 16;

  // Result width wide enough for len differences of width bits each.
  function automatic int sad_sum_w(input int width, input int len);
    return width + $clog2(len);
  endfunction

  // Mask that keeps the upper width-lsb bits of a width-bit operand.
  function automatic logic [63:0] approx_mask(input int width, input int lsb);
    logic [63:0] all_w;
    logic [63:0] low;
    all_w = (64'd1 << width) - 64'd1;
    low   = (64'd1 << lsb) - 64'd1;
    return all_w & ~low;
  endfunction

endpackage

// File: rtl/absdiff_trunc.sv
// rtl/absdiff_trunc.sv - absolute difference with optional LSB truncation
module absdiff_trunc
  import sad_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int APPROX_LSB = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             approx_en,
  output logic [WIDTH-1:0] d
);

  localparam logic [63:0]      MASK64 = approx_mask(WIDTH, APPROX_LSB);
  localparam logic [WIDTH-1:0] MASK   = MASK64[WIDTH-1:0];

  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;

  // Truncate both operands in approximate mode, then take |a - b| without a sign bit.
  always_comb begin
    a_m = approx_en ? (a & MASK) : a;
    b_m = approx_en ? (b & MASK) : b;
    d   = (a_m >= b_m) ? (a_m - b_m) : (b_m - a_m);
  end

endmodule

// File: rtl/sad_accum_stream.sv
// rtl/sad_accum_stream.sv - streaming windowed sum-of-absolute-differences engine
module sad_accum_stream
  import sad_pkg::*;
#(
  parameter int  WIDTH      = WIDTH_DEF,
  parameter int  LEN        = LEN_DEF,
  parameter int  APPROX_LSB = 2,
  localparam int SUM_W      = sad_sum_w(WIDTH, LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             approx_en,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sad
);

  localparam int               CNT_W = $clog2(LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

  logic [WIDTH-1:0] diff_w;
  logic             accept;

  logic [WIDTH-1:0] d1_q, d1_d;
  logic             d1_v_q, d1_v_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [SUM_W-1:0] out_sad_q, out_sad_d;

  absdiff_trunc #(
    .WIDTH      (WIDTH),
    .APPROX_LSB (APPROX_LSB)
  ) u_absdiff (
    .a         (in_a),
    .b         (in_b),
    .approx_en (approx_en),
    .d         (diff_w)
  );

  // A blocked output stalls the input; at most one beat can be in stage 1 then,
  // and it cannot finish another window because one just completed.
  assign in_ready  = ~clear & ~(out_valid_q & ~out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_sad   = out_sad_q;

  // Next-state for the difference stage, accumulator/counter and output register.
  always_comb begin
    d1_d        = accept ? diff_w : d1_q;
    d1_v_d      = accept;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sad_d   = out_sad_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (d1_v_q) begin
      if (cnt_q == LAST) begin
        out_sad_d   = acc_q + SUM_W'(d1_q);
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_q + SUM_W'(d1_q);
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (clear) begin
      d1_v_d      = 1'b0;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any partial window or pending result at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q        <= '0;
      d1_v_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sad_q   <= '0;
    end else begin
      d1_q        <= d1_d;
      d1_v_q      <= d1_v_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sad_q   <= out_sad_d;
    end
  end

endmodule

// File: tb/tb_sad_accum_stream.sv
// tb/tb_sad_accum_stream.sv - scoreboard bench for sad_accum_stream
module tb_sad_accum_stream;

  localparam int WIDTH      = 8;
  localparam int LEN        = 4;
  localparam int APPROX_LSB = 2;
  localparam int SUM_W      = WIDTH + $clog2(LEN);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             approx_en;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sad;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int w;
  int wsum;

  int               m_acc = 0;
  int               m_cnt = 0;
  logic [SUM_W-1:0] exp_q[$];
  int               out_cyc[$];
  logic [SUM_W-1:0] out_val[$];

  sad_accum_stream #(
    .WIDTH      (WIDTH),
    .LEN        (LEN),
    .APPROX_LSB (APPROX_LSB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .approx_en (approx_en),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sad   (out_sad)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_diff(input int a, input int b, input bit ap);
    int m;
    int am;
    int bm;
    m  = ap ? (((1 << WIDTH) - 1) & ~((1 << APPROX_LSB) - 1)) : ((1 << WIDTH) - 1);
    am = a & m;
    bm = b & m;
    return (am > bm) ? (am - bm) : (bm - am);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: model accepted beats, pop expected sums on output handshakes.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_acc = 0;
      m_cnt = 0;
      exp_q.delete();
    end else if (clear) begin
      m_acc = 0;
      m_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        out_cyc.push_back(cyc);
        out_val.push_back(out_sad);
        if (exp_q.size() == 0) check("sb_queue_nonempty", exp_q.size(), 1);
        else check("sb_out_sad", out_sad, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        m_acc += ref_diff(int'(in_a), int'(in_b), approx_en);
        m_cnt++;
        if (m_cnt == LEN) begin
          exp_q.push_back(SUM_W'(m_acc));
          m_acc = 0;
          m_cnt = 0;
        end
      end
    end
  end

  task automatic beat(input int a, input int b, input bit ap, output int waits);
    waits     = 0;
    in_a      = WIDTH'(a);
    in_b      = WIDTH'(b);
    approx_en = ap;
    in_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 200) begin
        check("in_ready_timeout", in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp);
    int g;
    g = 0;
    @(negedge clk);
    while (!out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out_sad, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    approx_en = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sad", out_sad, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Exact window and latency.
    beat(10, 3, 0, w); beat(3, 10, 0, w); beat(255, 0, 0, w); beat(0, 0, 0, w);
    check("lat_early", out_valid, 0);
    @(posedge clk); #1;
    check("lat_valid", out_valid, 1);
    check("exact_269", out_sad, 269);
    @(posedge clk); #1;
    check("exact_drained", out_valid, 0);

    // Approximate then exact on the same pairs.
    beat(13, 2, 1, w); beat(7, 4, 1, w); beat(255, 252, 1, w); beat(1, 3, 1, w);
    wait_out("approx_12", 12);
    beat(13, 2, 0, w); beat(7, 4, 0, w); beat(255, 252, 0, w); beat(1, 3, 0, w);
    wait_out("exact_19", 19);

    // Backpressure.
    out_ready = 1'b0;
    repeat (4) beat(5, 1, 0, w);
    in_a = 8'd255; in_b = 8'd0; approx_en = 1'b0; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_hold_sad", out_sad, 16);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) beat(255, 0, 0, w);
    wait_out("bp_1020", 1020);

    // Clear mid-window.
    beat(9, 1, 0, w); beat(9, 1, 0, w);
    in_a = 8'd1; in_b = 8'd0; in_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    check("clr_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_valid_low", out_valid, 0);
    repeat (4) beat(1, 0, 0, w);
    wait_out("clr_4", 4);

    // Async reset mid-window.
    repeat (3) beat(50, 0, 0, w);
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_sad", out_sad, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) beat(2, 0, 0, w);
    wait_out("arst_8", 8);

    // Back-to-back streaming windows.
    out_cyc.delete();
    out_val.delete();
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      beat(200, 50, 0, w);
      wsum += w;
    end
    check("stream_no_stall", wsum, 0);
    repeat (4) @(posedge clk);
    #1;
    check("stream_count", out_val.size(), 2);
    if (out_val.size() == 2) begin
      check("stream_sad0", out_val[0], 600);
      check("stream_sad1", out_val[1], 600);
      check("stream_gap", out_cyc[1] - out_cyc[0], LEN);
    end

    repeat (3) @(posedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
